// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcodes, format codes and buffer states shared by the immediate generator.
package imm_gen_pkg;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_INV} fmt_e;
    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_e;

    function automatic bit xlen_ok(input int xlen);
        return xlen == 32 || xlen == 64;
    endfunction
endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode_comb: combinational instruction -> {immediate, format} decoder.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);
    localparam bit RV64 = XLEN == 64;

    logic signed [31:0] i_s, s_s, b_s, u_s, j_s;
    logic [2:0] f3;

    // Build each immediate sign-extended to 32 bits; the XLEN cast extends further on RV64.
    assign i_s = 32'($signed(instr[31:20]));
    assign s_s = 32'($signed({instr[31:25], instr[11:7]}));
    assign b_s = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign u_s = {instr[31:12], 12'h000};
    assign j_s = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign f3  = instr[14:12];

    always_comb begin
        imm = '0;
        fmt = FMT_INV;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                fmt = FMT_I;
                imm = XLEN'(i_s);
            end
            OPC_OP_IMM32: begin
                fmt = RV64 ? FMT_I : FMT_INV;
                imm = RV64 ? XLEN'(i_s) : '0;
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'(s_s);
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'(b_s);
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'(u_s);
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'(j_s);
            end
            OPC_OP: fmt = FMT_R;
            OPC_OP32: fmt = RV64 ? FMT_R : FMT_INV;
            OPC_SYSTEM: begin
                case (f3)
                    3'b000: begin
                        fmt = FMT_I;
                        imm = XLEN'(i_s);
                    end
                    3'b001, 3'b010, 3'b011: begin
                        fmt = FMT_I;
                        imm = XLEN'(instr[31:20]);
                    end
                    3'b101, 3'b110, 3'b111: begin
                        fmt = FMT_Z;
                        imm = XLEN'(instr[19:15]);
                    end
                    default: fmt = FMT_INV;
                endcase
            end
            default: fmt = FMT_INV;
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-cycle pipelined immediate generator behind a 2-entry skid buffer.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [ERR_W-1:0] err_cnt
);
    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  dec_imm, skid_imm;
    fmt_e             dec_fmt, skid_fmt;
    logic [TAG_W-1:0] skid_tag;
    buf_e             state, state_nx;
    logic             acc, drn, load_out, load_skid, from_skid;

    imm_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr (in_instr),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;
    assign out_valid = state != BUF_EMPTY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BUF_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != BUF_FULL;
        end
    end

    // The output register is the head entry; the skid register only fills when it is held.
    always_comb begin
        state_nx  = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            BUF_EMPTY: begin
                load_out = acc;
                state_nx = acc ? BUF_ONE : BUF_EMPTY;
            end
            BUF_ONE: begin
                load_out  = acc & drn;
                load_skid = acc & !drn;
                state_nx  = (acc & !drn) ? BUF_FULL : (drn & !acc) ? BUF_EMPTY : BUF_ONE;
            end
            BUF_FULL: begin
                from_skid = drn;
                state_nx  = drn ? BUF_ONE : BUF_FULL;
            end
            default: state_nx = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm     <= '0;
            out_fmt     <= 3'd0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            skid_imm    <= '0;
            skid_fmt    <= FMT_R;
            skid_tag    <= '0;
        end else begin
            if (load_out) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_fmt == FMT_INV;
                out_tag     <= in_tag;
            end else if (from_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_fmt == FMT_INV;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
                skid_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt <= '0;
        else if (acc && dec_fmt == FMT_INV && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of RV32, RV64 and ERR_W=2 instances sharing one stimulus.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        o32_in_ready, o32_valid, o32_ill;
    logic [31:0] o32_imm;
    logic [2:0]  o32_fmt;
    logic [7:0]  o32_tag;
    logic [15:0] o32_err;
    logic        o64_in_ready, o64_valid, o64_ill;
    logic [63:0] o64_imm;
    logic [2:0]  o64_fmt;
    logic [7:0]  o64_tag;
    logic [15:0] o64_err;
    logic        oe_in_ready, oe_valid, oe_ill;
    logic [31:0] oe_imm;
    logic [2:0]  oe_fmt;
    logic [7:0]  oe_tag;
    logic [1:0]  oe_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ins;
        logic [7:0]  tag;
        logic [31:0] i32;
        logic [2:0]  f32;
        logic [63:0] i64;
        logic [2:0]  f64;
    } vec_t;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o32_in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(o32_valid), .out_ready(out_ready),
        .out_imm(o32_imm), .out_fmt(o32_fmt), .out_illegal(o32_ill), .out_tag(o32_tag),
        .err_cnt(o32_err)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o64_in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(o64_valid), .out_ready(out_ready),
        .out_imm(o64_imm), .out_fmt(o64_fmt), .out_illegal(o64_ill), .out_tag(o64_tag),
        .err_cnt(o64_err)
    );

    imm_gen_pipe #(.XLEN(32), .ERR_W(2)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(oe_in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(oe_valid), .out_ready(out_ready),
        .out_imm(oe_imm), .out_fmt(oe_fmt), .out_illegal(oe_ill), .out_tag(oe_tag),
        .err_cnt(oe_err)
    );

    task automatic send(input logic [31:0] ins, input logic [7:0] tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = ins;
        in_tag   = tag;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o32_valid); end
        checks++; if (o32_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", o32_in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (o32_imm !== 32'h0) begin errors++; $display("FAIL rst_imm got %h exp 0", o32_imm); end
        checks++; if (o32_fmt !== 3'd0 || o32_ill !== 1'b0) begin errors++; $display("FAIL rst_fmt got %0d/%b exp 0/0", o32_fmt, o32_ill); end
        checks++; if (o32_tag !== 8'h0 || o32_err !== 16'h0) begin errors++; $display("FAIL rst_tag_err got %h/%h exp 0/0", o32_tag, o32_err); end
        checks++; if (o64_imm !== 64'h0 || oe_err !== 2'd0) begin errors++; $display("FAIL rst_others got %h/%h exp 0/0", o64_imm, oe_err); end
    endtask

    task automatic test_basic;
        vec_t v[6];
        v[0] = '{32'h00A50293, 8'h11, 32'h0000000A, 3'd1, 64'h000000000000000A, 3'd1};
        v[1] = '{32'hFFF00093, 8'h12, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
        v[2] = '{32'h00208463, 8'h13, 32'h00000008, 3'd3, 64'h0000000000000008, 3'd3};
        v[3] = '{32'hFE20AE23, 8'h14, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2};
        v[4] = '{32'h001000EF, 8'h15, 32'h00000800, 3'd5, 64'h0000000000000800, 3'd5};
        v[5] = '{32'h002081B3, 8'h16, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0};
        for (int k = 0; k < 6; k++) begin
            send(v[k].ins, v[k].tag);
            checks++; if (o32_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b exp 1", k, o32_valid); end
            checks++; if (o32_imm !== v[k].i32) begin errors++; $display("FAIL basic_imm32[%0d] got %h exp %h", k, o32_imm, v[k].i32); end
            checks++; if (o32_fmt !== v[k].f32) begin errors++; $display("FAIL basic_fmt32[%0d] got %0d exp %0d", k, o32_fmt, v[k].f32); end
            checks++; if (o32_tag !== v[k].tag) begin errors++; $display("FAIL basic_tag[%0d] got %h exp %h", k, o32_tag, v[k].tag); end
            checks++; if (o64_imm !== v[k].i64) begin errors++; $display("FAIL basic_imm64[%0d] got %h exp %h", k, o64_imm, v[k].i64); end
            checks++; if (o64_fmt !== v[k].f64) begin errors++; $display("FAIL basic_fmt64[%0d] got %0d exp %0d", k, o64_fmt, v[k].f64); end
        end
    endtask

    task automatic test_rv64;
        vec_t v[3];
        v[0] = '{32'h80000537, 8'h21, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
        v[1] = '{32'h0050009B, 8'h22, 32'h00000000, 3'd7, 64'h0000000000000005, 3'd1};
        v[2] = '{32'h002081BB, 8'h23, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd0};
        checks++; if (o32_err !== 16'd0) begin errors++; $display("FAIL rv64_err_before got %0d exp 0", o32_err); end
        for (int k = 0; k < 3; k++) begin
            send(v[k].ins, v[k].tag);
            checks++; if (o32_imm !== v[k].i32 || o32_fmt !== v[k].f32) begin errors++; $display("FAIL rv64_dut32[%0d] got %h/%0d exp %h/%0d", k, o32_imm, o32_fmt, v[k].i32, v[k].f32); end
            checks++; if (o32_ill !== (v[k].f32 == 3'd7)) begin errors++; $display("FAIL rv64_ill32[%0d] got %b exp %b", k, o32_ill, v[k].f32 == 3'd7); end
            checks++; if (o64_imm !== v[k].i64 || o64_fmt !== v[k].f64) begin errors++; $display("FAIL rv64_dut64[%0d] got %h/%0d exp %h/%0d", k, o64_imm, o64_fmt, v[k].i64, v[k].f64); end
            checks++; if (o64_ill !== (v[k].f64 == 3'd7)) begin errors++; $display("FAIL rv64_ill64[%0d] got %b exp %b", k, o64_ill, v[k].f64 == 3'd7); end
            if (k == 1) begin
                checks++; if (o32_err !== 16'd1) begin errors++; $display("FAIL rv64_err_first got %0d exp 1", o32_err); end
            end
        end
        checks++; if (o32_err !== 16'd2 || o64_err !== 16'd0) begin errors++; $display("FAIL rv64_err got %0d/%0d exp 2/0", o32_err, o64_err); end
    endtask

    task automatic test_csr;
        vec_t v[4];
        v[0] = '{32'h30001073, 8'h31, 32'h00000300, 3'd1, 64'h0000000000000300, 3'd1};
        v[1] = '{32'h3002D073, 8'h32, 32'h00000005, 3'd6, 64'h0000000000000005, 3'd6};
        v[2] = '{32'h30004073, 8'h33, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7};
        v[3] = '{32'hF0002073, 8'h34, 32'h00000F00, 3'd1, 64'h0000000000000F00, 3'd1};
        for (int k = 0; k < 4; k++) begin
            send(v[k].ins, v[k].tag);
            checks++; if (o32_imm !== v[k].i32 || o32_fmt !== v[k].f32) begin errors++; $display("FAIL csr32[%0d] got %h/%0d exp %h/%0d", k, o32_imm, o32_fmt, v[k].i32, v[k].f32); end
            checks++; if (o64_imm !== v[k].i64 || o64_fmt !== v[k].f64) begin errors++; $display("FAIL csr64[%0d] got %h/%0d exp %h/%0d", k, o64_imm, o64_fmt, v[k].i64, v[k].f64); end
            checks++; if (o32_ill !== (v[k].f32 == 3'd7)) begin errors++; $display("FAIL csr_ill[%0d] got %b exp %b", k, o32_ill, v[k].f32 == 3'd7); end
        end
        checks++; if (o32_err !== 16'd3 || oe_err !== 2'd3) begin errors++; $display("FAIL csr_err got %0d/%0d exp 3/3", o32_err, oe_err); end
    endtask

    task automatic test_illegal;
        send(32'h00000000, 8'h41);
        checks++; if (o32_fmt !== 3'd7 || o32_ill !== 1'b1 || o32_imm !== 32'h0) begin errors++; $display("FAIL ill_zero got %0d/%b/%h exp 7/1/0", o32_fmt, o32_ill, o32_imm); end
        checks++; if (o32_err !== 16'd4) begin errors++; $display("FAIL ill_err32 got %0d exp 4", o32_err); end
        for (int k = 0; k < 5; k++) send(32'hFFFFFFFF, 8'(k));
        checks++; if (o32_err !== 16'd9) begin errors++; $display("FAIL ill_err32_after got %0d exp 9", o32_err); end
        checks++; if (oe_err !== 2'd3) begin errors++; $display("FAIL ill_err_sat got %0d exp 3", oe_err); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c > 0) begin
                checks++; if (o32_valid !== 1'b1 || o32_imm !== 32'(c + 31) || o32_tag !== 8'(c - 1)) begin errors++; $display("FAIL b2b[%0d] got %b/%h/%h exp 1/%h/%h", c, o32_valid, o32_imm, o32_tag, 32'(c + 31), 8'(c - 1)); end
            end
            in_valid = c < 4;
            in_instr = 32'((c + 32) << 20) | 32'h13;
            in_tag   = 8'(c);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        int idx, got;
        logic acc, dr;
        idx = 0;
        got = 0;
        @(negedge clk);
        for (int c = 0; c < 40 && got < 4; c++) begin
            in_valid  = idx < 4;
            in_instr  = 32'((idx + 1) << 20) | 32'h13;
            in_tag    = 8'(idx + 1);
            out_ready = c >= 5;
            if (c == 2) begin
                checks++; if (o32_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", o32_in_ready); end
            end
            if (c == 1 || c == 4) begin
                checks++; if (o32_valid !== 1'b1 || o32_imm !== 32'd1 || o32_tag !== 8'd1) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h/%h exp 1/1/1", c, o32_valid, o32_imm, o32_tag); end
            end
            if (c == 4) begin
                checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepted got %0d exp 2", idx); end
            end
            dr  = o32_valid & out_ready;
            acc = in_valid & o32_in_ready;
            if (dr) begin
                checks++; if (o32_imm !== 32'(got + 1) || o32_tag !== 8'(got + 1)) begin errors++; $display("FAIL bp_order[%0d] got %h/%h exp %h/%h", got, o32_imm, o32_tag, 32'(got + 1), 8'(got + 1)); end
                got++;
            end
            @(negedge clk);
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got); end
        checks++; if (o32_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", o32_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send(32'h00100013, 8'h51);
        send(32'h00200013, 8'h52);
        checks++; if (o32_valid !== 1'b1 || o32_in_ready !== 1'b0) begin errors++; $display("FAIL rm_full got %b/%b exp 1/0", o32_valid, o32_in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o32_valid !== 1'b0 || o32_in_ready !== 1'b1) begin errors++; $display("FAIL rm_async got %b/%b exp 0/1", o32_valid, o32_in_ready); end
        checks++; if (o32_err !== 16'd0 || o32_imm !== 32'h0) begin errors++; $display("FAIL rm_clear got %h/%h exp 0/0", o32_err, o32_imm); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (o32_valid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d] got %b exp 0", k, o32_valid); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rv64;
        test_csr;
        test_illegal;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
